// File: rtl/throughout_mon_pkg.sv
// Shared definitions for the throughout_mon checker.
//   LenMax     : largest legal window length.
//   DefCntW    : default width of the pass/fail tallies.
//   cnt_t      : tally type at the default width.
//   fail_num_w : width needed to report how many attempts one fail pulse killed.
package throughout_mon_pkg;

  localparam int unsigned LenMax  = 32;
  localparam int unsigned DefCntW = 16;

  typedef logic [DefCntW-1:0] cnt_t;

  // Up to len attempts can be in flight, so the count needs to reach len itself.
  function automatic int unsigned fail_num_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating accumulator: adds inc_i when en_i is high and sticks at all-ones.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low clear
//   en_i   : add enable
//   inc_i  : increment value
//   cnt_o  : current tally
module sat_cnt
  import throughout_mon_pkg::*;
#(
  parameter int unsigned Width = DefCntW,
  parameter int unsigned IncW  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [IncW-1:0]  inc_i,
  output logic [Width-1:0] cnt_o
);

  // One spare bit so the carry out of the add is visible.
  localparam int unsigned SumW = ((Width > IncW) ? Width : IncW) + 1;

  logic [Width-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]  sum;

  always_comb begin
    sum   = SumW'(cnt_q) + SumW'(inc_i);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (sum > SumW'({Width{1'b1}})) ? {Width{1'b1}} : sum[Width-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/throughout_mon.sv
// Run-time checker for: $rose(trig) |=> (hold throughout cond[*LEN]), with dis acting as
// a synchronous disable. Each attempt is reported by a one-cycle pass or fail pulse.
// Optional tallies are built only when THROUGHOUT_MON_COUNT_EN is defined; otherwise
// pass_cnt/fail_cnt read 0.
// Ports:
//   clock    : clock, rising edge
//   resetn   : synchronous active-low reset
//   dis      : synchronous abort, drops all in-flight attempts silently
//   trig     : antecedent, an attempt starts on its rise
//   hold     : must stay high throughout the window
//   cond     : must be high for LEN consecutive cycles
//   pass     : registered pulse, an attempt completed
//   fail     : registered pulse, in-flight attempts were killed
//   fail_num : number of attempts killed by the current fail pulse
//   active   : combinational, at least one attempt in flight
//   pass_cnt : saturating pass tally
//   fail_cnt : saturating fail tally
module throughout_mon
  import throughout_mon_pkg::*;
#(
  parameter int unsigned LEN   = 2,
  parameter int unsigned CNT_W = $bits(cnt_t)
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        dis,
  input  logic                        trig,
  input  logic                        hold,
  input  logic                        cond,
  output logic                        pass,
  output logic                        fail,
  output logic [fail_num_w(LEN)-1:0]  fail_num,
  output logic                        active,
  output logic [CNT_W-1:0]            pass_cnt,
  output logic [CNT_W-1:0]            fail_cnt
);

  localparam int unsigned FnW = fail_num_w(LEN);

  if (LEN < 1 || LEN > LenMax) begin : gen_bad_len
    $error("throughout_mon: LEN out of range");
  end

  logic           trig_q;
  logic           ok, rose;
  logic [LEN-1:0] pend_q, pend_d;
  logic [FnW-1:0] pop;
  logic           pass_q, pass_d;
  logic           fail_q, fail_d;
  logic [FnW-1:0] fnum_q, fnum_d;

  // Loads through reset so a trig held high across reset is not seen as a rise.
  always_ff @(posedge clock) begin
    trig_q <= trig;
  end

  always_comb begin
    ok   = hold & cond;
    rose = trig & ~trig_q;
    pop  = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      pop = pop + FnW'(pend_q[i]);
    end
    pend_d = '0;
    pass_d = 1'b0;
    fail_d = 1'b0;
    fnum_d = '0;
    if (!dis) begin
      if (ok) begin
        // pend[k] = attempt on its (k+1)-th check; the top bit leaving means LEN good cycles.
        pend_d = pend_q << 1;
        pass_d = pend_q[LEN-1];
      end else begin
        fnum_d = pop;
        fail_d = |pend_q;
      end
      // A new attempt is enqueued regardless of the verdict on older ones.
      pend_d[0] = pend_d[0] | rose;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      fnum_q <= '0;
    end else begin
      pend_q <= pend_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      fnum_q <= fnum_d;
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign fail_num = fnum_q;
  assign active   = |pend_q;

`ifdef THROUGHOUT_MON_COUNT_EN
  sat_cnt #(
    .Width (CNT_W),
    .IncW  (1)
  ) u_pass_cnt (
    .clk_i  (clock),
    .rst_ni (resetn),
    .en_i   (pass_d),
    .inc_i  (1'b1),
    .cnt_o  (pass_cnt)
  );

  sat_cnt #(
    .Width (CNT_W),
    .IncW  (FnW)
  ) u_fail_cnt (
    .clk_i  (clock),
    .rst_ni (resetn),
    .en_i   (fail_d),
    .inc_i  (fnum_d),
    .cnt_o  (fail_cnt)
  );
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_throughout_mon.sv
// Bench for throughout_mon: two instances (LEN=2/CNT_W=2 and LEN=4/CNT_W=16) share the
// same inputs and are each compared every cycle against an attempt-list model.
module tb_throughout_mon;

  logic clock = 1'b0;
  logic resetn, dis, trig, hold, cond;

  logic       pass_a, fail_a, active_a;
  logic [1:0] fnum_a;
  logic [1:0] pcnt_a, fcnt_a;

  logic        pass_b, fail_b, active_b;
  logic [2:0]  fnum_b;
  logic [15:0] pcnt_b, fcnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  throughout_mon #(.LEN(2), .CNT_W(2)) u_a (
    .clock    (clock),
    .resetn   (resetn),
    .dis      (dis),
    .trig     (trig),
    .hold     (hold),
    .cond     (cond),
    .pass     (pass_a),
    .fail     (fail_a),
    .fail_num (fnum_a),
    .active   (active_a),
    .pass_cnt (pcnt_a),
    .fail_cnt (fcnt_a)
  );

  throughout_mon #(.LEN(4), .CNT_W(16)) u_b (
    .clock    (clock),
    .resetn   (resetn),
    .dis      (dis),
    .trig     (trig),
    .hold     (hold),
    .cond     (cond),
    .pass     (pass_b),
    .fail     (fail_b),
    .fail_num (fnum_b),
    .active   (active_b),
    .pass_cnt (pcnt_b),
    .fail_cnt (fcnt_b)
  );

  // Model: each in-flight attempt is an entry holding how many good cycles it has seen.
  int  lens[2] = '{2, 4};
  int  cmax[2] = '{3, 65535};
  int  age[2][64];
  int  n[2];
  bit  ep[2], ef[2];
  int  efn[2], epc[2], efc[2];
  bit  trig_prev;

  task automatic model_update();
    bit ok, rose, p;
    int m;
    ok   = hold && cond;
    rose = trig && !trig_prev;
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        n[d] = 0; ep[d] = 0; ef[d] = 0; efn[d] = 0; epc[d] = 0; efc[d] = 0;
      end else if (dis) begin
        n[d] = 0; ep[d] = 0; ef[d] = 0; efn[d] = 0;
      end else begin
        if (ok) begin
          p = 0;
          m = 0;
          for (int i = 0; i < n[d]; i++) begin
            if (age[d][i] + 1 >= lens[d]) p = 1;
            else begin
              age[d][m] = age[d][i] + 1;
              m++;
            end
          end
          n[d]   = m;
          ep[d]  = p;
          ef[d]  = 0;
          efn[d] = 0;
          if (p) epc[d] = (epc[d] + 1 > cmax[d]) ? cmax[d] : epc[d] + 1;
        end else begin
          efn[d] = n[d];
          ef[d]  = (n[d] > 0);
          ep[d]  = 0;
          efc[d] = (efc[d] + n[d] > cmax[d]) ? cmax[d] : efc[d] + n[d];
          n[d]   = 0;
        end
        if (rose) begin
          age[d][n[d]] = 0;
          n[d]++;
        end
      end
    end
    trig_prev = trig;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int pc, fc;
    for (int d = 0; d < 2; d++) begin
`ifdef THROUGHOUT_MON_COUNT_EN
      pc = epc[d];
      fc = efc[d];
`else
      pc = 0;
      fc = 0;
`endif
      if (d == 0) begin
        chk("a.pass",     32'(pass_a),   32'(ep[0]));
        chk("a.fail",     32'(fail_a),   32'(ef[0]));
        chk("a.fail_num", 32'(fnum_a),   32'(efn[0]));
        chk("a.active",   32'(active_a), 32'(n[0] != 0));
        chk("a.pass_cnt", 32'(pcnt_a),   32'(pc));
        chk("a.fail_cnt", 32'(fcnt_a),   32'(fc));
      end else begin
        chk("b.pass",     32'(pass_b),   32'(ep[1]));
        chk("b.fail",     32'(fail_b),   32'(ef[1]));
        chk("b.fail_num", 32'(fnum_b),   32'(efn[1]));
        chk("b.active",   32'(active_b), 32'(n[1] != 0));
        chk("b.pass_cnt", 32'(pcnt_b),   32'(pc));
        chk("b.fail_cnt", 32'(fcnt_b),   32'(fc));
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then sample just after the edge.
  task automatic step(input bit r, input bit d, input bit t, input bit h, input bit c);
    resetn = r; dis = d; trig = t; hold = h; cond = c;
    model_update();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    resetn = 0; dis = 0; trig = 0; hold = 0; cond = 0;
    trig_prev = 0;
    #1;
    // Reset: all outputs must read 0.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    idle(2);

    // Single passing attempt (LEN=2 passes, LEN=4 fails when ok drops).
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    idle(3);

    // hold low while cond high: fails.
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    idle(2);

    // Overlapping rises every 2 cycles with ok high throughout.
    for (int i = 0; i < 6; i++) step(1, 0, (i % 2 == 0), 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
    idle(2);

    // Same rises, ok drops later: several attempts killed at once.
    for (int i = 0; i < 6; i++) step(1, 0, (i % 2 == 0), 1, 1);
    step(1, 0, 0, 0, 1);
    idle(3);

    // Reset mid-window with trig held high across reset.
    step(1, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 1);
    idle(2);

    // dis mid-window, rise in the dis cycle ignored, rise next cycle starts.
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 1, 1, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1);
    idle(2);

    // Many passes and fails to drive the narrow tallies into saturation.
    for (int i = 0; i < 16; i++) step(1, 0, (i % 2 == 0), 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, (i % 2 == 0), (i % 4 != 1), 1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) != 0), ($urandom_range(29) == 0), ($urandom_range(2) == 0),
           ($urandom_range(9) != 0), ($urandom_range(99) < 85));
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
